pipe_stage_buffer: RTL and testbench

Parametrised elastic pipeline-stage register that replaces the fixed, always-loading stage registers between pipeline stages (decode/execute, execute/memory, memory/writeback). It carries a control field and a data payload from one stage to the next with a valid/ready handshake, an optional two-entry skid buffer, a flush input for branch/jump kills, and bubble-safe control zeroing. A saturating counter records downstream back-pressure cycles for performance debug.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/sat_counter.sv | 45 ++++
 rtl/pipe_stage_buffer.sv | 244 ++++++++++++++++++++++++
 tb/tb_pipe_stage_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline-stage registers:
//   - pipe_state_e      : occupancy state of an elastic stage (EMPTY/ONE/TWO)
//   - *_CTRL_W/*_DATA_W : default field widths for each stage boundary
//   - REG_WRITE..BRANCH : bit positions of the architectural control bits
//                         inside the control field
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Occupancy of an elastic stage. The encoding is fixed so that waveforms
  // and debug dumps stay comparable across stage boundaries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // Default widths per stage boundary.
  localparam int ID_EX_CTRL_W  = 14;
  localparam int ID_EX_DATA_W  = 160;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int EX_MEM_DATA_W = 112;
  localparam int MEM_WB_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 72;

  // Control-field bit positions. Every bit that causes an architectural side
  // effect must sit inside the control field so bubble zeroing covers it.
  localparam int REG_WRITE = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_READ  = 2;
  localparam int JUMP      = 3;
  localparam int BRANCH    = 4;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance-debug statistics. Counts one per cycle
// while inc_i is high and sticks at all-ones instead of wrapping, so a long
// stall can never read back as a short one.
//
// Ports:
//   clk_i    in   1      clock, rising edge
//   rst_i    in   1      synchronous active-high reset, clears the count
//   clear_i  in   1      synchronous clear (lower priority than rst_i)
//   inc_i    in   1      count this cycle
//   cnt_o    out  CNT_W  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins over increment, and the increment is blocked
  // once the maximum value has been reached.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc_i && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule : sat_counter

// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
// Elastic register between two pipeline stages. Carries a control field and a
// payload with a valid/ready handshake. SKID=1 builds a two-entry skid buffer
// whose in_ready_o is a flop (no out_ready_i -> in_ready_o path); SKID=0 builds
// a single entry with a combinational in_ready_o for short stages.
// flush_i kills every held entry and the incoming beat. The control field is
// kept at zero in the output register whenever the output is not valid, so a
// bubble can never write the register file or memory.
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous active-high reset
//   flush_i      in   1       kill held entries and incoming beat
//   in_valid_i   in   1       upstream beat valid
//   in_ready_o   out  1       stage accepts a beat this cycle
//   in_ctrl_i    in   CTRL_W  upstream control field
//   in_data_i    in   DATA_W  upstream payload
//   out_valid_o  out  1       downstream beat valid
//   out_ready_i  in   1       downstream accepts (low = stall)
//   out_ctrl_o   out  CTRL_W  held control, zero when out_valid_o is low
//   out_data_o   out  DATA_W  held payload, keeps last value when invalid
//   stall_cnt_o  out  CNT_W   saturating count of out_valid_o & ~out_ready_i
// -----------------------------------------------------------------------------
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Main entry: always the one presented downstream.
  logic              main_valid_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic              stall_s;

  generate
    if (SKID != 0) begin : g_skid
      // Overflow entry, only meaningful in state TWO.
      logic [CTRL_W-1:0] skid_ctrl_r;
      logic [DATA_W-1:0] skid_data_r;
      pipe_state_e       state_r;
      pipe_state_e       state_nxt_s;
      logic              in_ready_r;
      logic              in_fire_s;
      logic              out_fire_s;
      logic              load_main_in_s;
      logic              load_main_skid_s;
      logic              load_skid_s;

      assign in_fire_s  = in_valid_i & in_ready_r;
      assign out_fire_s = main_valid_r & out_ready_i;

      // Next occupancy state; flush overrides every handshake.
      always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
          state_nxt_s = EMPTY;
        end else begin
          case (state_r)
            EMPTY: begin
              if (in_fire_s) begin
                state_nxt_s = ONE;
              end else begin
                state_nxt_s = EMPTY;
              end
            end
            ONE: begin
              if (in_fire_s && !out_fire_s) begin
                state_nxt_s = TWO;
              end else if (!in_fire_s && out_fire_s) begin
                state_nxt_s = EMPTY;
              end else begin
                state_nxt_s = ONE;
              end
            end
            TWO: begin
              if (out_fire_s) begin
                state_nxt_s = ONE;
              end else begin
                state_nxt_s = TWO;
              end
            end
            default: begin
              state_nxt_s = EMPTY;
            end
          endcase
        end
      end

      // Data-path steering: which entry loads from where this cycle. A beat
      // accepted during a flush is consumed upstream but never stored.
      always_comb begin
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush_i) begin
          load_main_in_s   = 1'b0;
          load_main_skid_s = 1'b0;
          load_skid_s      = 1'b0;
        end else begin
          case (state_r)
            EMPTY: begin
              load_main_in_s = in_fire_s;
            end
            ONE: begin
              load_main_in_s = in_fire_s & out_fire_s;
              load_skid_s    = in_fire_s & ~out_fire_s;
            end
            TWO: begin
              // The skid beat is older than anything upstream, so it moves
              // to the main entry before any new beat is taken.
              load_main_skid_s = out_fire_s;
            end
            default: begin
              load_main_in_s   = 1'b0;
              load_main_skid_s = 1'b0;
              load_skid_s      = 1'b0;
            end
          endcase
        end
      end

      // State, registered ready and main entry. in_ready_r looks at the next
      // state so it already reflects this cycle's handshakes.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_r      <= EMPTY;
          in_ready_r   <= 1'b1;
          main_valid_r <= 1'b0;
          main_ctrl_r  <= {CTRL_W{1'b0}};
          main_data_r  <= {DATA_W{1'b0}};
        end else begin
          state_r      <= state_nxt_s;
          in_ready_r   <= (state_nxt_s != TWO);
          main_valid_r <= (state_nxt_s != EMPTY);
          if (load_main_in_s) begin
            main_ctrl_r <= in_ctrl_i;
            main_data_r <= in_data_i;
          end else if (load_main_skid_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_data_r <= skid_data_r;
          end else if (state_nxt_s == EMPTY) begin
            // Bubble: control zeroed, payload left untouched.
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= main_data_r;
          end else begin
            main_ctrl_r <= main_ctrl_r;
            main_data_r <= main_data_r;
          end
        end
      end

      // Skid entry: captures the beat that arrives while main is stalled.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          skid_ctrl_r <= {CTRL_W{1'b0}};
          skid_data_r <= {DATA_W{1'b0}};
        end else if (load_skid_s) begin
          skid_ctrl_r <= in_ctrl_i;
          skid_data_r <= in_data_i;
        end else begin
          skid_ctrl_r <= skid_ctrl_r;
          skid_data_r <= skid_data_r;
        end
      end

      assign in_ready_o = in_ready_r;

    end else begin : g_single
      logic in_ready_s;
      logic in_fire_s;
      logic out_fire_s;

      // Space exists if empty or if the held beat leaves this cycle.
      assign in_ready_s = ~main_valid_r | out_ready_i;
      assign in_fire_s  = in_valid_i & in_ready_s;
      assign out_fire_s = main_valid_r & out_ready_i;

      // Single entry: flush, then load, then drain.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          main_valid_r <= 1'b0;
          main_ctrl_r  <= {CTRL_W{1'b0}};
          main_data_r  <= {DATA_W{1'b0}};
        end else if (flush_i) begin
          main_valid_r <= 1'b0;
          main_ctrl_r  <= {CTRL_W{1'b0}};
          main_data_r  <= main_data_r;
        end else if (in_fire_s) begin
          main_valid_r <= 1'b1;
          main_ctrl_r  <= in_ctrl_i;
          main_data_r  <= in_data_i;
        end else if (out_fire_s) begin
          main_valid_r <= 1'b0;
          main_ctrl_r  <= {CTRL_W{1'b0}};
          main_data_r  <= main_data_r;
        end else begin
          main_valid_r <= main_valid_r;
          main_ctrl_r  <= main_ctrl_r;
          main_data_r  <= main_data_r;
        end
      end

      assign in_ready_o = in_ready_s;
    end
  endgenerate

  // A stall is a presented beat that downstream refuses; flush does not
  // hide it.
  assign stall_s = main_valid_r & ~out_ready_i;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .inc_i   (stall_s),
    .cnt_o   (stall_cnt_o)
  );

  assign out_valid_o = main_valid_r;
  // main_ctrl_r is held at zero whenever main_valid_r is low.
  assign out_ctrl_o  = main_ctrl_r;
  assign out_data_o  = main_data_r;

endmodule : pipe_stage_buffer

// File: tb/tb_pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buffer
// Three instances: dut_a (SKID=1, 16-bit counter), dut_s (same stimulus as
// dut_a, 4-bit counter for saturation) and dut_b (SKID=0). The reference model
// is a FIFO of accepted beats per stage (capacity 2 or 1) plus an integer
// stall count; a negedge monitor compares the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buffer;

  localparam int CW = 14;
  localparam int DW = 32;

  typedef logic [CW+DW-1:0] beat_t;

  logic          clk;
  logic          rst;
  // Instance A / S stimulus
  logic          flush_a, in_valid_a, out_ready_a;
  logic [CW-1:0] in_ctrl_a;
  logic [DW-1:0] in_data_a;
  logic          in_ready_a, out_valid_a;
  logic [CW-1:0] out_ctrl_a;
  logic [DW-1:0] out_data_a;
  logic [15:0]   stall_a;
  logic          in_ready_s, out_valid_s;
  logic [CW-1:0] out_ctrl_s;
  logic [DW-1:0] out_data_s;
  logic [3:0]    stall_s;
  // Instance B stimulus
  logic          flush_b, in_valid_b, out_ready_b;
  logic [CW-1:0] in_ctrl_b;
  logic [DW-1:0] in_data_b;
  logic          in_ready_b, out_valid_b;
  logic [CW-1:0] out_ctrl_b;
  logic [DW-1:0] out_data_b;
  logic [15:0]   stall_b;

  int checks = 0;
  int failures = 0;

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .in_valid_i(in_valid_a),
    .in_ready_o(in_ready_a), .in_ctrl_i(in_ctrl_a), .in_data_i(in_data_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .out_ctrl_o(out_ctrl_a),
    .out_data_o(out_data_a), .stall_cnt_o(stall_a));

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .in_valid_i(in_valid_a),
    .in_ready_o(in_ready_s), .in_ctrl_i(in_ctrl_a), .in_data_i(in_data_a),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready_a), .out_ctrl_o(out_ctrl_s),
    .out_data_o(out_data_s), .stall_cnt_o(stall_s));

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .in_valid_i(in_valid_b),
    .in_ready_o(in_ready_b), .in_ctrl_i(in_ctrl_b), .in_data_i(in_data_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_ctrl_o(out_ctrl_b),
    .out_data_o(out_data_b), .stall_cnt_o(stall_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + monitor ----------------
  beat_t qa[$];
  beat_t qb[$];
  int    cnt_a = 0, cnt_s = 0, cnt_b = 0;
  int    pops_a = 0;
  bit    live = 1'b0;
  bit    ev_a, er_a, ev_b, er_b;
  beat_t hd;

  always @(negedge clk) begin
    if (live) begin
      // Stage A (capacity 2, ready registered = fewer than two held)
      ev_a = (qa.size() > 0);
      er_a = (qa.size() < 2);
      chk("a_out_valid", out_valid_a, ev_a);
      chk("s_out_valid", out_valid_s, ev_a);
      chk("a_in_ready", in_ready_a, er_a);
      chk("s_in_ready", in_ready_s, er_a);
      if (ev_a) begin
        hd = qa[0];
        chk("a_out_ctrl", out_ctrl_a, hd[CW+DW-1:DW]);
        chk("a_out_data", out_data_a, hd[DW-1:0]);
        chk("s_out_data", out_data_s, hd[DW-1:0]);
      end else begin
        chk("a_bubble_ctrl", out_ctrl_a, 0);
        chk("s_bubble_ctrl", out_ctrl_s, 0);
      end
      chk("a_stall_cnt", stall_a, cnt_a);
      chk("s_stall_cnt", stall_s, cnt_s);
      // Stage B (capacity 1, ready combinational)
      ev_b = (qb.size() > 0);
      er_b = !ev_b || out_ready_b;
      chk("b_out_valid", out_valid_b, ev_b);
      chk("b_in_ready", in_ready_b, er_b);
      if (ev_b) begin
        hd = qb[0];
        chk("b_out_ctrl", out_ctrl_b, hd[CW+DW-1:DW]);
        chk("b_out_data", out_data_b, hd[DW-1:0]);
      end else begin
        chk("b_bubble_ctrl", out_ctrl_b, 0);
      end
      chk("b_stall_cnt", stall_b, cnt_b);
    end
    // Advance the model to what the coming edge produces.
    if (rst) begin
      qa.delete();
      qb.delete();
      cnt_a = 0; cnt_s = 0; cnt_b = 0;
      live = 1'b1;
    end else if (live) begin
      if (ev_a && !out_ready_a) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_s < 15) cnt_s++;
      end
      if (ev_a && out_ready_a) begin
        void'(qa.pop_front());
        pops_a++;
      end
      if (flush_a) qa.delete();
      else if (in_valid_a && er_a) qa.push_back({in_ctrl_a, in_data_a});

      if (ev_b && !out_ready_b && cnt_b < 65535) cnt_b++;
      if (ev_b && out_ready_b) void'(qb.pop_front());
      if (flush_b) qb.delete();
      else if (in_valid_b && er_b) qb.push_back({in_ctrl_b, in_data_b});
    end
  end

  // ---------------- stimulus ----------------
  int p0;
  logic [15:0] s0;

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; in_valid_a = 1'b1; in_ctrl_a = 14'h3FFF; in_data_a = 32'hDEADBEEF;
    out_ready_a = 1'b0;
    flush_b = 1'b0; in_valid_b = 1'b1; in_ctrl_b = 14'h3FFF; in_data_b = 32'hDEADBEEF;
    out_ready_b = 1'b0;
    repeat (2) step();
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_out_ctrl", out_ctrl_a, 14'h0);
    chk("rst_stall", stall_a, 16'h0);
    chk("rst_in_ready", in_ready_a, 1'b1);
    chk("rst_b_out_valid", out_valid_b, 1'b0);
    rst = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;

    // Streaming: 8 beats, downstream always ready
    out_ready_a = 1'b1;
    p0 = pops_a;
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = i;
      in_ctrl_a  = 14'($urandom_range(0, 16383));
      step();
      chk("stream_latency_data", out_data_a, i);
    end
    in_valid_a = 1'b0;
    step();
    chk("stream_beats_out", pops_a - p0, 8);

    // Back-pressure: A then B with downstream stalled
    out_ready_a = 1'b0;
    s0 = stall_a;
    in_valid_a = 1'b1; in_data_a = 32'hAAAA0001; in_ctrl_a = 14'h0011;
    step();
    in_data_a = 32'hBBBB0002; in_ctrl_a = 14'h0022;
    step();
    in_valid_a = 1'b0;
    chk("bp_in_ready_low", in_ready_a, 1'b0);
    chk("bp_hold_a", out_data_a, 32'hAAAA0001);
    repeat (2) step();
    out_ready_a = 1'b1;
    step();
    chk("bp_then_b", out_data_a, 32'hBBBB0002);
    step();
    chk("bp_drained", out_valid_a, 1'b0);
    chk("bp_stall_cycles", stall_a - s0, 16'd3);

    // Flush in state TWO with beat C offered
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 32'h0A0A0A0A; in_ctrl_a = 14'h001F;
    step();
    in_data_a = 32'h0B0B0B0B;
    step();
    chk("fl_full", in_ready_a, 1'b0);
    in_data_a = 32'h0C0C0C0C; flush_a = 1'b1;
    step();
    flush_a = 1'b0; in_valid_a = 1'b0;
    chk("fl_out_valid", out_valid_a, 1'b0);
    chk("fl_out_ctrl", out_ctrl_a, 14'h0);
    chk("fl_in_ready", in_ready_a, 1'b1);
    out_ready_a = 1'b1;
    repeat (3) step();

    // Saturation of the 4-bit counter
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 32'h5A5A5A5A; in_ctrl_a = 14'h0001;
    step();
    in_valid_a = 1'b0;
    repeat (20) step();
    chk("sat_stall_15", stall_s, 4'hF);
    out_ready_a = 1'b1;
    repeat (2) step();

    // Randomized traffic on both modes
    for (int c = 0; c < 1000; c++) begin
      in_valid_a  = 1'($urandom_range(0, 1));
      out_ready_a = ($urandom_range(0, 9) < 7);
      flush_a     = ($urandom_range(0, 39) == 0);
      in_data_a   = $urandom;
      in_ctrl_a   = 14'($urandom_range(0, 16383));
      in_valid_b  = 1'($urandom_range(0, 1));
      out_ready_b = 1'($urandom_range(0, 1));
      flush_b     = ($urandom_range(0, 49) == 0);
      in_data_b   = $urandom;
      in_ctrl_b   = 14'($urandom_range(0, 16383));
      step();
    end

    // Reset in the middle of traffic discards everything
    flush_a = 1'b0; flush_b = 1'b0;
    in_valid_a = 1'b1; in_valid_b = 1'b1; out_ready_a = 1'b0; out_ready_b = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    chk("midrst_out_valid", out_valid_a, 1'b0);
    chk("midrst_stall", stall_a, 16'h0);
    chk("midrst_b_valid", out_valid_b, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_buffer
